mult_div_seq: RTL and testbench
===============================

Name: mult_div_seq

Overview:
- Iterative multi-cycle multiply/divide unit with integrated HI/LO result registers.
- Replaces the combinational mult/div blocks, their 64-bit select mux and the separate HI/LO registers in the multicycle CPU datapath.
- Width is parametrised; signed and unsigned modes are supported.
- Uses a start/busy/done handshake with the control unit; reports divide-by-zero.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits. Must be at least 4 and even.

Ports:
- clk  input  1  clock; rising edge active
- reset  input  1  asynchronous, active-high reset
- start  input  1  request an operation; sampled only in IDLE
- op  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU
- a  input  WIDTH  multiplicand or dividend (from regA)
- b  input  WIDTH  multiplier or divisor (from regB)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; hi/lo updated on the same edge
- div_zero  output  1  one-cycle pulse with done when a DIV/DIVU had b==0
- hi  output  WIDTH  MULT: upper product half; DIV: remainder
- lo  output  WIDTH  MULT: lower product half; DIV: quotient

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE.
  - hi=0, lo=0, busy=0, done=0, div_zero=0.
  - Internal counter and accumulators cleared.
  - An operation in flight is discarded; no done is produced.
- States: IDLE, CALC, FIX.
- IDLE:
  - Edge E0 with start=1 latches op, |a| and |b| (absolute value for signed ops, raw value for unsigned), result signs, count=WIDTH.
  - Next state CALC; busy=1 from E0.
  - Special case, DIV/DIVU with b==0 at E0: no computation. State stays IDLE, busy stays 0. done=1 and div_zero=1 for the single cycle after E0. hi/lo unchanged.
- CALC:
  - One radix-2 step per edge; count decrements.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; remainder is WIDTH+1 bits internally.
  - After the WIDTH-th step (edge E_WIDTH), go to FIX.
- FIX, edge E_(WIDTH+1):
  - Apply sign correction.
  - Signed MULT: negate the 2*WIDTH product if the operand signs differ.
  - Signed DIV: quotient negated if the signs differ; remainder takes the dividend's sign (truncation toward zero).
  - Write hi/lo, done=1, busy=0, next state IDLE.
- done and div_zero clear on the following edge.
- Latency: start edge to result edge is WIDTH+1 edges (33 for WIDTH=32). Divide-by-zero takes 1 edge.
- Overflow case MIN / -1 (signed): lo=MIN, hi=0. This is the natural wrap of the magnitude algorithm; no exception.
- Magnitude of MIN is held as WIDTH+1 bits so that 2^(WIDTH-1) is representable.
- start while busy: ignored; a and b are not re-sampled.
- start on the same edge that done is asserted: accepted, since state is already IDLE.
- hi/lo hold their last value indefinitely; they are readable at any time, including while busy (old values).
- b==0 for MULT/MULTU is legal (result 0).

Decomposition:
- Package mult_div_pkg:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - 2-bit state encoding ST_IDLE, ST_CALC, ST_FIX.
  - Shared by the control unit, which drives op.
- One combinational sub-module, md_sign_fix:
  - Inputs: product or quotient/remainder, sign flags, op.
  - Output: corrected hi/lo.
- The FSM, counter and datapath registers stay in mult_div_seq.

Test Plan (WIDTH=32):
- MULT, a=0xFFFFFFFD (-3), b=7 -> after 33 edges done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 33 cycles.
- MULTU, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Divide pair:
  - DIV, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Then DIVU, a=7, b=2 -> lo=3, hi=1.
- DIV, a=5, b=0 with hi/lo preloaded from the previous test -> done=div_zero=1 one cycle after the start edge, busy never rises, hi=1 and lo=3 unchanged.
- DIV, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, div_zero=0.
- Handshake and reset:
  - Pulse start again at cycle 10 of a MULT with different operands -> ignored; result matches the first operands.
  - Assert reset at cycle 15 of a DIV -> immediately busy=0, hi=lo=0, no done pulse.
  - A new start after reset completes normally.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit and the control unit
// that drives its op input.
package mult_div_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  function automatic logic is_div(input op_t o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic is_signed(input op_t o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Final sign correction: turns the magnitude product or quotient/remainder
// held in the accumulator into the architectural hi/lo values.
module md_sign_fix
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic               neg_q,
  input  logic               neg_r,
  input  logic [1:0]         op,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic               sgn;
  logic               div;

  always_comb begin
    sgn  = is_signed(op_t'(op));
    div  = is_div(op_t'(op));
    prod = (sgn && neg_q) ? -acc : acc;
    quo  = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
    hi   = prod[2*WIDTH-1:WIDTH];
    lo   = prod[WIDTH-1:0];
    if (div) begin
      // Remainder follows the dividend's sign: truncation toward zero.
      lo = (sgn && neg_q) ? -quo : quo;
      hi = (sgn && neg_r) ? -rem : rem;
    end
  end

endmodule

// File: rtl/mult_div_seq.sv
// Iterative radix-2 multiply/divide unit with integrated HI/LO registers and a
// start/busy/done handshake.
module mult_div_seq
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state;
  op_t                op_q;
  logic [WIDTH:0]     mag_a;
  logic [WIDTH:0]     mag_b;
  logic               neg_q;
  logic               neg_r;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;

  op_t                op_in;
  logic               sgn_in;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH:0]     a_abs;
  logic [WIDTH:0]     b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     trial;
  logic               ge;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Magnitudes are WIDTH+1 bits so that |MIN| = 2^(WIDTH-1) stays positive.
  always_comb begin
    op_in  = op_t'(op);
    sgn_in = is_signed(op_in);
    a_neg  = sgn_in & a[WIDTH-1];
    b_neg  = sgn_in & b[WIDTH-1];
    a_abs  = a_neg ? -{a_neg, a} : {1'b0, a};
    b_abs  = b_neg ? -{b_neg, b} : {1'b0, b};
  end

  // Multiply: lo half holds the multiplier, shifted right one bit per step.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? mag_a : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  // Divide: hi half is the partial remainder, lo half shifts dividend out and
  // quotient bits in. A successful trial always leaves a WIDTH-bit remainder.
  always_comb begin
    trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge       = (trial >= mag_b);
    diff     = trial[WIDTH-1:0] - mag_b[WIDTH-1:0];
    div_next = {(ge ? diff : trial[WIDTH-1:0]), acc[WIDTH-2:0], ge};
  end

  md_sign_fix #(
    .WIDTH (WIDTH)
  ) u_sign_fix (
    .acc   (acc),
    .neg_q (neg_q),
    .neg_r (neg_r),
    .op    (op_q),
    .hi    (fix_hi),
    .lo    (fix_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= OP_MULT;
      mag_a    <= '0;
      mag_b    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      count    <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (is_div(op_in) && (b == '0)) begin
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              op_q  <= op_in;
              mag_a <= a_abs;
              mag_b <= b_abs;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              count <= CW'(WIDTH);
              acc   <= is_div(op_in) ? {{WIDTH{1'b0}}, a_abs[WIDTH-1:0]}
                                     : {{WIDTH{1'b0}}, b_abs[WIDTH-1:0]};
              busy  <= 1'b1;
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          acc   <= is_div(op_q) ? div_next : mul_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: directed cases plus randomized
// operations compared against a plain-arithmetic reference model.
module tb_mult_div_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always #5 clk = ~clk;

  mult_div_seq #(
    .WIDTH (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: 64-bit integer arithmetic; SV division truncates toward zero.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] rh, output logic [W-1:0] rl, output bit dz);
    longint      sx;
    longint      sy;
    logic [63:0] p;
    bit          sg;
    sg = (o == 2'b00) || (o == 2'b10);
    sx = sg ? longint'($signed(x)) : longint'({32'b0, x});
    sy = sg ? longint'($signed(y)) : longint'({32'b0, y});
    dz = 1'b0;
    rh = '0;
    rl = '0;
    if (o[1] == 1'b0) begin
      p  = sx * sy;
      rh = p[63:32];
      rl = p[31:0];
    end else if (y == '0) begin
      dz = 1'b1;
    end else begin
      p  = sx / sy;
      rl = p[31:0];
      p  = sx % sy;
      rh = p[31:0];
    end
  endfunction

  // Called #1 after a clock edge; poke >= 0 re-pulses start at that busy cycle.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int poke);
    logic [W-1:0] eh;
    logic [W-1:0] el;
    bit           dz;
    int           edges;
    int           busy_cnt;
    model(o, x, y, eh, el, dz);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = 2'($urandom);
    if (dz) begin
      check("dz_done", 64'(done), 64'd1);
      check("dz_flag", 64'(div_zero), 64'd1);
      check("dz_busy", 64'(busy), 64'd0);
      check("dz_hi", 64'(hi), 64'(m_hi));
      check("dz_lo", 64'(lo), 64'(m_lo));
      @(posedge clk);
      #1;
      check("dz_clear", 64'({done, div_zero, busy}), 64'd0);
    end else begin
      check("busy_rise", 64'(busy), 64'd1);
      check("hi_hold", 64'(hi), 64'(m_hi));
      check("lo_hold", 64'(lo), 64'(m_lo));
      edges    = 0;
      busy_cnt = 1;
      while (!done && edges < 200) begin
        if (edges == poke) begin
          start = 1'b1;
          a     = $urandom;
          b     = $urandom;
        end else begin
          start = 1'b0;
        end
        @(posedge clk);
        #1;
        edges++;
        if (busy) busy_cnt++;
      end
      start = 1'b0;
      check("latency", 64'(edges), 64'(W + 1));
      check("busy_cycles", 64'(busy_cnt), 64'(W + 1));
      check("hi", 64'(hi), 64'(eh));
      check("lo", 64'(lo), 64'(el));
      check("dz_low", 64'(div_zero), 64'd0);
      check("busy_fall", 64'(busy), 64'd0);
      m_hi = eh;
      m_lo = el;
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int dc;
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'({done, div_zero}), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;

    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, -1);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1);
    do_op(2'b11, 32'd7, 32'd2, -1);
    do_op(2'b10, 32'd5, 32'd0, -1);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    do_op(2'b00, 32'h0001_2345, 32'hFFFF_E57B, 10);
    do_op(2'b01, 32'hDEAD_BEEF, 32'd0, -1);

    // Reset in the middle of a divide discards it without a done pulse.
    op    = 2'b10;
    a     = 32'h1234_5678;
    b     = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_hi", 64'(hi), 64'd0);
    check("mid_rst_lo", 64'(lo), 64'd0);
    check("mid_rst_done", 64'({done, div_zero}), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_hi  = '0;
    m_lo  = '0;
    dc    = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) dc++;
    end
    check("no_done_after_rst", 64'(dc), 64'd0);
    do_op(2'b11, 32'd100, 32'd7, -1);

    for (int i = 0; i < 40; i++) begin
      do_op(2'($urandom_range(0, 3)), pick(), pick(), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
